uart_host: RTL and testbench

// - Host-side initiator for the chip's regfile UART link: serialises write/read commands onto posi, deserialises read replies from piso.
// - Sits in the test/FPGA controller facing one chip; a local command/response handshake is the user interface.
// - Packet (18b, LSB first): [0] wrb (1=write), [8:1] data, [16:9] addr, [17] parity = ~^bits[16:0] (odd parity overall).
// - Frame: start bit 0, 18 packet bits, stop bit 1; line idles high.

---
 rtl/uart_host.sv | 190 +++++++++++++++++++
 tb/tb_uart_host.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_host.sv
// Host-side initiator for the regfile UART link: serialises 18-bit write/read packets on posi
// and deserialises read replies from piso, reporting each transaction with a one-cycle response.
module uart_host #(
  parameter int CLKS_PER_BIT = 16,
  parameter int GAP_BITS     = 2,
  parameter int TIMEOUT_CLKS = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_status,
  output logic       busy,
  output logic       posi,
  input  logic       piso,
  output logic [2:0] fsm_state
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CLK_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [4:0]    GAP_LAST = 5'(GAP_BITS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [1:0] ST_OK = 2'b00, ST_PAR = 2'b01, ST_FRM = 2'b10, ST_TO = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_TX, S_GAP, S_WAIT, S_RX, S_DONE} state_t;

  state_t          state, next_state;
  logic            armed;
  logic            wr_q;
  logic [7:0]      addr_q;
  logic [18:0]     tx_shift;
  logic [17:0]     rx_shift;
  logic [CW-1:0]   clk_cnt;
  logic [4:0]      bit_cnt;
  logic [TW-1:0]   to_cnt;
  logic            piso_s1, piso_s2, piso_d;
  logic            bit_end, mid_bit, piso_fall, accept;
  logic            rx_frame_bad, rx_par_bad;

  assign bit_end   = (clk_cnt == CLK_LAST);
  assign mid_bit   = (clk_cnt == CLK_MID);
  assign piso_fall = piso_d & ~piso_s2;
  // Command handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
  // cmd_ready then stays low until the cycle after that command's rsp_valid pulse.
  assign accept    = cmd_valid & cmd_ready;
  // Evaluated at the stop-bit sample, so piso_s2 is the stop bit itself.
  assign rx_frame_bad = ~piso_s2 | rx_shift[0] | (rx_shift[16:9] != addr_q);
  assign rx_par_bad   = ((~^rx_shift[16:0]) != rx_shift[17]);
  assign fsm_state    = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = armed;
        if (cmd_valid && armed) next_state = S_TX;
      end
      S_TX: begin
        busy = 1'b1;
        if (bit_end && bit_cnt == 5'd19) next_state = S_GAP;
      end
      S_GAP: begin
        busy = 1'b1;
        if (bit_end && bit_cnt == GAP_LAST) next_state = wr_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (piso_fall)              next_state = S_RX;
        else if (to_cnt == TO_LAST) next_state = S_DONE;
      end
      S_RX: begin
        busy = 1'b1;
        if (mid_bit && ((bit_cnt == 5'd0 && piso_s2) || bit_cnt == 5'd19)) next_state = S_DONE;
      end
      S_DONE: begin
        rsp_valid  = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed      <= 1'b0;
      posi       <= 1'b1;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      piso_s1    <= 1'b1;
      piso_s2    <= 1'b1;
      piso_d     <= 1'b1;
      rsp_rdata  <= '0;
      rsp_status <= ST_OK;
    end else begin
      armed   <= 1'b1;
      piso_s1 <= piso;
      piso_s2 <= piso_s1;
      piso_d  <= piso_s2;
      case (state)
        S_IDLE: begin
          if (accept) begin
            wr_q     <= cmd_write;
            addr_q   <= cmd_addr;
            posi     <= 1'b0;
            tx_shift <= {1'b1, ~^{cmd_addr, cmd_wdata, cmd_write}, cmd_addr, cmd_wdata, cmd_write};
            clk_cnt  <= '0;
            bit_cnt  <= '0;
          end
        end
        S_TX: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == 5'd19) begin
              bit_cnt <= '0;
              posi    <= 1'b1;
            end else begin
              bit_cnt  <= bit_cnt + 5'd1;
              posi     <= tx_shift[0];
              tx_shift <= {1'b1, tx_shift[18:1]};
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_GAP: begin
          to_cnt   <= '0;
          rx_shift <= '0;
          if (bit_end) begin
            clk_cnt <= '0;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == GAP_LAST && wr_q) begin
              rsp_rdata  <= '0;
              rsp_status <= ST_OK;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (piso_fall) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            rsp_rdata  <= '0;
            rsp_status <= ST_TO;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_RX: begin
          clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
          if (mid_bit) begin
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd0) begin
              if (piso_s2) begin
                rsp_rdata  <= rx_shift[8:1];
                rsp_status <= ST_FRM;
              end
            end else if (bit_cnt == 5'd19) begin
              rsp_rdata  <= rx_shift[8:1];
              rsp_status <= rx_frame_bad ? ST_FRM : (rx_par_bad ? ST_PAR : ST_OK);
            end else begin
              rx_shift <= {piso_s2, rx_shift[17:1]};
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_host.sv
// Directed bench for uart_host: command driver, piso reply BFM, posi frame capture, and a
// response monitor that pops expected {latency, status, rdata} entries on each rsp_valid.
module tb_uart_host;
  localparam int CPB = 16;
  localparam int GAP = 2;
  localparam int TO  = 4096;
  localparam int TXG = (20 + GAP) * CPB;  // accept edge to the edge that enters DONE/WAIT

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       piso = 1'b1;
  logic       cmd_ready, rsp_valid, busy, posi;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_status;
  logic [2:0] fsm_state;

  uart_host #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .busy(busy), .posi(posi), .piso(piso), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0, n_rsp = 0, n_exp = 0, acc_cyc = 0;
  // {latency in edges after the accept edge (0 = unchecked), status, rdata}
  logic [25:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input int lat, input logic [1:0] st, input logic [7:0] rd);
    exp_q.push_back({16'(lat), st, rd});
    n_exp++;
  endtask

  // driver tasks
  task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    for (int k = 0; k < 200 && !cmd_ready; k++) @(negedge clk);
    if (!cmd_ready) begin
      n_tests++; n_fail++;
      $display("FAIL cmd_accept: cmd_ready stayed 0, required 1");
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 acc_cyc = cyc;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(input int budget);
    for (int k = 0; k < budget && n_rsp < n_exp; k++) @(negedge clk);
    check("rsp_arrived", 32'(n_rsp >= n_exp), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic send_reply(input logic [17:0] pkt, input logic stop);
    piso = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      piso = pkt[i];
      repeat (CPB) @(negedge clk);
    end
    piso = stop;
    repeat (CPB) @(negedge clk);
    piso = 1'b1;
  endtask

  task automatic capture_frame(output logic [19:0] f);
    f = '0;
    repeat (CPB / 2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      f[i] = posi;
      if (i < 19) repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic read_txn(input logic [7:0] a, input logic [17:0] pkt, input logic stop,
                          input logic [1:0] st, input logic [7:0] rd);
    expect_rsp(0, st, rd);
    issue(1'b0, a, 8'h00);
    repeat (TXG + 20) @(negedge clk);
    send_reply(pkt, stop);
    wait_rsp(400);
  endtask

  // scoreboard monitor
  initial begin : monitor
    logic [25:0] e;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid) begin
        n_rsp++;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_rsp: got status %0d rdata 0x%0h, required no response",
                   rsp_status, rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          check("rsp_status", 32'(rsp_status), 32'(e[9:8]));
          check("rsp_rdata", 32'(rsp_rdata), 32'(e[7:0]));
          check("busy_at_rsp", 32'(busy), 32'd0);
          if (e[25:10] != 16'd0) check("rsp_latency", 32'(cyc - acc_cyc), 32'(e[25:10]));
          @(negedge clk);
          check("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [19:0] frame;
    #12;
    check("reset_posi", 32'(posi), 32'd1);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("reset_rsp_status", 32'(rsp_status), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("ready_before_first_clk", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("ready_first_clk", 32'(cmd_ready), 32'd1);

    // Write 0x12 <- 0xA5: rsp_valid in clock 353 counting the start-bit clock as 1.
    expect_rsp(TXG, 2'b00, 8'h00);
    issue(1'b1, 8'h12, 8'hA5);
    check("busy_after_accept", 32'(busy), 32'd1);
    capture_frame(frame);
    check("posi_frame_wr_12_a5", 32'(frame), 32'h84A96);
    wait_rsp(200);

    // Write 0xFF <- 0x00, parity 0
    expect_rsp(TXG, 2'b00, 8'h00);
    issue(1'b1, 8'hFF, 8'h00);
    capture_frame(frame);
    check("posi_frame_wr_ff_00", 32'(frame), 32'hBFC02);
    wait_rsp(200);

    // Read replies, packet = {parity, addr, data, wrb}
    read_txn(8'h3C, {1'b1, 8'h3C, 8'h5A, 1'b0}, 1'b1, 2'b00, 8'h5A);
    read_txn(8'h3C, {1'b0, 8'h3C, 8'h5A, 1'b0}, 1'b1, 2'b01, 8'h5A);
    read_txn(8'h3C, {1'b0, 8'h3D, 8'h5A, 1'b0}, 1'b1, 2'b10, 8'h5A);
    read_txn(8'h3C, {1'b1, 8'h3C, 8'h5A, 1'b0}, 1'b0, 2'b10, 8'h5A);
    read_txn(8'h3C, {1'b0, 8'h3C, 8'h5A, 1'b1}, 1'b1, 2'b10, 8'h5A);
    read_txn(8'h00, {1'b1, 8'h00, 8'hFF, 1'b0}, 1'b1, 2'b00, 8'hFF);

    // Timeout: piso held high; DONE entered TO edges after WAIT entry
    expect_rsp(TXG + TO, 2'b11, 8'h00);
    issue(1'b0, 8'h3C, 8'h00);
    wait_rsp(TXG + TO + 100);

    // Reset during TX bit 7 (data[5] of 0x85 = 0), no response may follow
    issue(1'b1, 8'h12, 8'h85);
    repeat (7 * CPB + CPB / 2) @(negedge clk);
    check("posi_tx_bit7", 32'(posi), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("posi_async_reset", 32'(posi), 32'd1);
    check("busy_async_reset", 32'(busy), 32'd0);
    check("ready_in_reset", 32'(cmd_ready), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(cmd_ready), 32'd1);
    repeat (TXG + 50) @(negedge clk);
    check("no_rsp_after_abort", 32'(n_rsp), 32'(n_exp));

    expect_rsp(TXG, 2'b00, 8'h00);
    issue(1'b1, 8'h12, 8'hA5);
    capture_frame(frame);
    check("posi_frame_after_reset", 32'(frame), 32'h84A96);
    wait_rsp(200);
    read_txn(8'h3C, {1'b1, 8'h3C, 8'h5A, 1'b0}, 1'b1, 2'b00, 8'h5A);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
